// File: rtl/xm23_pkg.sv
// rtl/xm23_pkg.sv - XM-23 arithmetic/logic decode constants, field positions and payload type
package xm23_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_ADDC = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_SUBC = 4'h3;
    localparam logic [3:0] ALU_DADD = 4'h4;
    localparam logic [3:0] ALU_CMP  = 4'h5;
    localparam logic [3:0] ALU_XOR  = 4'h6;
    localparam logic [3:0] ALU_AND  = 4'h7;
    localparam logic [3:0] ALU_OR   = 4'h8;
    localparam logic [3:0] ALU_BIT  = 4'h9;
    localparam logic [3:0] ALU_BIC  = 4'hA;
    localparam logic [3:0] ALU_BIS  = 4'hB;
    localparam logic [3:0] ALU_SRA  = 4'hC;
    localparam logic [3:0] ALU_RRC  = 4'hD;

    localparam logic [3:0] GRP_ALU   = 4'b0100;
    localparam logic [3:0] OPF_SHIFT = 4'hD;

    localparam int F_GRP_HI = 15;
    localparam int F_GRP_LO = 12;
    localparam int F_OP_HI  = 11;
    localparam int F_OP_LO  = 8;
    localparam int F_RC     = 7;
    localparam int F_WB     = 6;
    localparam int F_SRC_HI = 5;
    localparam int F_SRC_LO = 3;
    localparam int F_DST_HI = 2;
    localparam int F_DST_LO = 0;
    localparam int F_SHF    = 3;

    typedef struct packed {
        logic [4:0]  op;
        logic [15:0] src;
        logic [15:0] dst;
        logic [2:0]  dst_reg;
        logic        wr_en;
        logic [15:0] pc;
    } ex_payload_t;

    function automatic logic [15:0] const_val(input logic [2:0] idx);
        case (idx)
            3'd0:    const_val = 16'h0000;
            3'd1:    const_val = 16'h0001;
            3'd2:    const_val = 16'h0002;
            3'd3:    const_val = 16'h0004;
            3'd4:    const_val = 16'h0008;
            3'd5:    const_val = 16'h0010;
            3'd6:    const_val = 16'h0020;
            default: const_val = 16'hFFFF;
        endcase
    endfunction

endpackage

// File: rtl/dec_scoreboard.sv
// rtl/dec_scoreboard.sv - in-flight destination tracking and RAW/WAW hazard compare
module dec_scoreboard #(
    parameter int NREG = 8,
    parameter int RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_i,
    input  logic [RW-1:0] set_reg_i,
    input  logic          clr_i,
    input  logic [RW-1:0] clr_reg_i,
    input  logic          inflight_i,
    input  logic [RW-1:0] inflight_reg_i,
    input  logic          src_chk_i,
    input  logic [RW-1:0] src_reg_i,
    input  logic [RW-1:0] dst_reg_i,
    output logic          hazard_o
);

    logic [NREG-1:0] busy_q, busy_d;
    logic            src_hit, dst_hit;

    // Clear first so a same-cycle set of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) busy_d[clr_reg_i] = 1'b0;
        if (set_i) busy_d[set_reg_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    // The op sitting in the ALU stage is not yet in busy_q, so compare it directly.
    always_comb begin
        src_hit  = busy_q[src_reg_i] | (inflight_i & (inflight_reg_i == src_reg_i));
        dst_hit  = busy_q[dst_reg_i] | (inflight_i & (inflight_reg_i == dst_reg_i));
        hazard_o = dst_hit | (src_chk_i & src_hit);
    end

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - XM-23 arithmetic/logic decode with registered ALU payload
module instr_decode_stage
    import xm23_pkg::*;
#(
    parameter int NREG     = 8,
    parameter int ILLCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid,
    output logic                if_ready,
    input  logic [15:0]         if_instr,
    input  logic [15:0]         if_pc,
    output logic [2:0]          rf_src_sel,
    output logic [2:0]          rf_dst_sel,
    input  logic [15:0]         rf_src_data,
    input  logic [15:0]         rf_dst_data,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [4:0]          ex_op,
    output logic [15:0]         ex_src,
    output logic [15:0]         ex_dst,
    output logic [2:0]          ex_dst_reg,
    output logic                ex_wr_en,
    output logic [15:0]         ex_pc,
    input  logic                wb_valid,
    input  logic [2:0]          wb_reg,
    input  logic                flush,
    output logic                illegal,
    output logic [ILLCNT_W-1:0] illegal_count
);

    logic [3:0]          grp, opf, op4;
    logic                legal, src_chk, hazard_raw, hazard, accept;
    logic                ex_valid_q, ex_valid_d, illegal_q, illegal_d;
    logic [ILLCNT_W-1:0] cnt_q, cnt_d;
    ex_payload_t         pay_q, pay_d, pay_new;

    assign grp        = if_instr[F_GRP_HI:F_GRP_LO];
    assign opf        = if_instr[F_OP_HI:F_OP_LO];
    assign rf_src_sel = if_instr[F_SRC_HI:F_SRC_LO];
    assign rf_dst_sel = if_instr[F_DST_HI:F_DST_LO];

    always_comb begin
        legal = 1'b0;
        op4   = opf;
        if (grp == GRP_ALU) begin
            if (opf <= ALU_BIS) begin
                legal = 1'b1;
            end else if (opf == OPF_SHIFT && if_instr[F_SRC_HI:F_SRC_HI-1] == 2'b00) begin
                legal = 1'b1;
                op4   = if_instr[F_SHF] ? ALU_RRC : ALU_SRA;
            end
        end
    end

    always_comb begin
        pay_new.op      = {op4, if_instr[F_WB]};
        pay_new.src     = if_instr[F_RC] ? const_val(rf_src_sel) : rf_src_data;
        pay_new.dst     = rf_dst_data;
        pay_new.dst_reg = rf_dst_sel;
        pay_new.wr_en   = (op4 != ALU_CMP) && (op4 != ALU_BIT);
        pay_new.pc      = if_pc;
    end

    // Shifts reuse the source field as an opcode extension, so it is not a register read.
    assign src_chk = ~if_instr[F_RC] & (op4 < ALU_SRA);

    dec_scoreboard #(.NREG(NREG)) u_sb (
        .clk            (clk),
        .rst            (rst),
        .set_i          (ex_valid_q & ex_ready & pay_q.wr_en),
        .set_reg_i      (pay_q.dst_reg),
        .clr_i          (wb_valid),
        .clr_reg_i      (wb_reg),
        .inflight_i     (ex_valid_q & pay_q.wr_en),
        .inflight_reg_i (pay_q.dst_reg),
        .src_chk_i      (src_chk),
        .src_reg_i      (rf_src_sel),
        .dst_reg_i      (rf_dst_sel),
        .hazard_o       (hazard_raw)
    );

    assign hazard   = legal & hazard_raw;
    assign if_ready = (~ex_valid_q | ex_ready) & ~hazard & ~flush;
    assign accept   = if_valid & if_ready;

    always_comb begin
        ex_valid_d = ex_valid_q;
        pay_d      = pay_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (accept && legal) begin
            ex_valid_d = 1'b1;
            pay_d      = pay_new;
        end else if (ex_valid_q && ex_ready) begin
            ex_valid_d = 1'b0;
        end
        illegal_d = accept & ~legal;
        cnt_d     = cnt_q;
        if (illegal_d && cnt_q != {ILLCNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            pay_q      <= '0;
            illegal_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            pay_q      <= pay_d;
            illegal_q  <= illegal_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_op         = pay_q.op;
    assign ex_src        = pay_q.src;
    assign ex_dst        = pay_q.dst;
    assign ex_dst_reg    = pay_q.dst_reg;
    assign ex_wr_en      = pay_q.wr_en;
    assign ex_pc         = pay_q.pc;
    assign illegal       = illegal_q;
    assign illegal_count = cnt_q;

endmodule
